i2s_receiver: RTL



---
 rtl/i2s_pkg.sv | 13 +
 rtl/i2s_sync_edge.sv | 40 ++++
 rtl/i2s_receiver.sv | 129 ++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared I2S definitions: receiver FSM states and channel encodings.
package i2s_pkg;

    typedef enum logic [1:0] {
        S_ALIGN,
        S_SHIFT,
        S_WAIT
    } i2s_state_e;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_sync_edge.sv
// Brings sck/ws/sd into the clk domain through equal-depth synchronizers and
// flags each synchronized rising edge of sck with a one-cycle pulse.
module i2s_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sck_i,
    input  logic ws_i,
    input  logic sd_i,
    output logic ws_o,
    output logic sd_o,
    output logic sck_rise_o
);

    logic [SYNC_STAGES-1:0] sck_q;
    logic [SYNC_STAGES-1:0] ws_q;
    logic [SYNC_STAGES-1:0] sd_q;
    logic                   sck_prev_q;

    // Equal depth on all three lines keeps ws/sd aligned with the sck edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_q      <= '0;
            ws_q       <= '0;
            sd_q       <= '0;
            sck_prev_q <= 1'b0;
        end else begin
            sck_q      <= {sck_q[SYNC_STAGES-2:0], sck_i};
            ws_q       <= {ws_q[SYNC_STAGES-2:0], ws_i};
            sd_q       <= {sd_q[SYNC_STAGES-2:0], sd_i};
            sck_prev_q <= sck_q[SYNC_STAGES-1];
        end
    end

    assign ws_o       = ws_q[SYNC_STAGES-1];
    assign sd_o       = sd_q[SYNC_STAGES-1];
    assign sck_rise_o = sck_q[SYNC_STAGES-1] & ~sck_prev_q;

endmodule

// File: rtl/i2s_receiver.sv
// I2S deserializer: frames BITS-wide MSB-first words on ws edges and holds
// each one on a ready/valid output, flagging dropped and short words.
module i2s_receiver
    import i2s_pkg::*;
#(
    parameter int unsigned BITS        = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sck,
    input  logic            ws,
    input  logic            sd,
    output logic [BITS-1:0] o_data,
    output logic            o_right,
    output logic            o_valid,
    input  logic            o_ready,
    output logic            o_overflow,
    output logic            o_short
);

    localparam int unsigned CntW = $clog2(BITS + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(BITS);

    logic ws_s, sd_s, rise, ws_edge;

    i2s_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst       (rst),
        .sck_i     (sck),
        .ws_i      (ws),
        .sd_i      (sd),
        .ws_o      (ws_s),
        .sd_o      (sd_s),
        .sck_rise_o(rise)
    );

    i2s_state_e      state_q, state_d;
    logic [BITS-1:0] shift_q, shift_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            cur_ch_q, cur_ch_d;
    logic            ws_prev_q;
    logic            complete, short_p;

    assign ws_edge = rise & (ws_s != ws_prev_q);

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        cur_ch_d = cur_ch_q;
        complete = 1'b0;
        short_p  = 1'b0;
        unique case (state_q)
            S_ALIGN: begin
                if (ws_edge) begin
                    cur_ch_d = ws_s;
                    cnt_d    = '0;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt_q == CntMax) begin
                    complete = 1'b1;
                    state_d  = S_WAIT;
                end else if (ws_edge) begin
                    // The edge-cycle bit belongs to the word just abandoned.
                    short_p  = 1'b1;
                    cur_ch_d = ws_s;
                    cnt_d    = '0;
                end else if (rise) begin
                    shift_d = {shift_q[BITS-2:0], sd_s};
                    cnt_d   = cnt_q + CntW'(1);
                end
            end
            S_WAIT: begin
                if (ws_edge) begin
                    cur_ch_d = ws_s;
                    cnt_d    = '0;
                    state_d  = S_SHIFT;
                end
            end
            default: state_d = S_ALIGN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_ALIGN;
            shift_q   <= '0;
            cnt_q     <= '0;
            cur_ch_q  <= CH_LEFT;
            ws_prev_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            cur_ch_q <= cur_ch_d;
            if (rise) begin
                ws_prev_q <= ws_s;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_data     <= '0;
            o_right    <= CH_LEFT;
            o_valid    <= 1'b0;
            o_overflow <= 1'b0;
            o_short    <= 1'b0;
        end else begin
            o_overflow <= 1'b0;
            o_short    <= short_p;
            if (complete && (!o_valid || o_ready)) begin
                o_data  <= shift_q;
                o_right <= cur_ch_q;
                o_valid <= 1'b1;
            end else if (complete) begin
                o_overflow <= 1'b1;
            end else if (o_valid && o_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule
